// File: rtl/esp_boot_seq.sv
// ESP8266 power-up/reset sequencer exposed as a bus peripheral.
// Drives the module EN/RST pins, waits for first UART activity, retries on timeout.
module esp_boot_seq #(
  parameter int unsigned RST_CYCLES  = 50000,
  parameter int unsigned BOOT_CYCLES = 10000000,
  parameter int unsigned RSP_TIMEOUT = 25000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  input  logic        rx_activity,
  output logic        mod_en,
  output logic        mod_rst,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESET    = 3'd1,
    ST_BOOT     = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_READY    = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] count_reg;
  logic [1:0]  retry_reg, retry_next;
  logic [1:0]  retry_inc;
  logic        ctrl_wr, start, abort;
  logic        busy;
  logic [15:0] status;
  logic        en_next, rst_next, done_next;
  logic        unused_din;

  assign ctrl_wr    = cs & wr & (addr == 4'h0);
  assign start      = ctrl_wr & d_in[0];
  assign abort      = ctrl_wr & d_in[1];
  assign unused_din = ^d_in[15:2];
  assign retry_inc  = retry_reg + 2'd1;

  assign busy   = (state_reg == ST_RESET) || (state_reg == ST_BOOT) || (state_reg == ST_WAIT_RSP);
  assign status = {8'b0, state_reg, retry_reg, (state_reg == ST_FAIL), (state_reg == ST_READY), busy};

  // Abort overrides everything, including a start in the same write.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_READY, ST_FAIL: begin
          if (start) begin
            state_next = ST_RESET;
            retry_next = 2'd0;
          end
        end
        ST_RESET: begin
          if (count_reg == RST_CYCLES - 1) state_next = ST_BOOT;
        end
        ST_BOOT: begin
          if (count_reg == BOOT_CYCLES - 1) state_next = ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          if (rx_activity) begin
            state_next = ST_READY;
          end else if (count_reg == RSP_TIMEOUT - 1) begin
            retry_next = retry_inc;
            state_next = (retry_inc == 2'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Pins are decoded from the next state so they switch on the transition edge.
  always_comb begin
    en_next   = (state_next == ST_RESET) || (state_next == ST_BOOT) ||
                (state_next == ST_WAIT_RSP) || (state_next == ST_READY);
    rst_next  = (state_next == ST_BOOT) || (state_next == ST_WAIT_RSP) || (state_next == ST_READY);
    done_next = (state_next != state_reg) &&
                ((state_next == ST_READY) || (state_next == ST_FAIL));
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      retry_reg <= 2'd0;
      mod_en    <= 1'b0;
      mod_rst   <= 1'b0;
      done      <= 1'b0;
      d_out     <= 16'h0000;
    end else begin
      state_reg <= state_next;
      retry_reg <= retry_next;
      count_reg <= (state_next != state_reg) ? 32'd0 : count_reg + 32'd1;
      mod_en    <= en_next;
      mod_rst   <= rst_next;
      done      <= done_next;
      if (cs && rd) begin
        d_out <= (addr == 4'h2) ? status : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_esp_boot_seq.sv
// Directed bench for esp_boot_seq: stimulus pushes expected reads/done events,
// a monitor pops and compares whenever the DUT presents read data or a done pulse.
module tb_esp_boot_seq;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [15:0] d_in = 16'h0000;
  logic        rx_activity = 1'b0;
  logic [15:0] d_out;
  logic        mod_en;
  logic        mod_rst;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [15:0] rd_q[$];
  logic [1:0]  done_q[$];
  logic        rd_vld = 1'b0;
  logic [15:0] exp_rd;
  logic [1:0]  exp_done;

  always #5 clk = ~clk;

  esp_boot_seq #(
    .RST_CYCLES (4),
    .BOOT_CYCLES(8),
    .RSP_TIMEOUT(16),
    .MAX_RETRY  (2)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .d_in       (d_in),
    .d_out      (d_out),
    .rx_activity(rx_activity),
    .mod_en     (mod_en),
    .mod_rst    (mod_rst),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read data is valid the cycle after a cs&rd edge.
  always @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) rd_vld <= 1'b0;
    else          rd_vld <= cs && rd;
  end

  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", {16'h0, d_out}, 32'hFFFF_FFFF);
      end else begin
        exp_rd = rd_q.pop_front();
        $display("[TB] read status got 0x%04h expected 0x%04h", d_out, exp_rd);
        chk("status_read", {16'h0, d_out}, {16'h0, exp_rd});
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_done = done_q.pop_front();
        $display("[TB] done pulse pins en/rst got %b expected %b", {mod_en, mod_rst}, exp_done);
        chk("done_pins", {30'h0, mod_en, mod_rst}, {30'h0, exp_done});
      end
    end
  end

  // Bus tasks start at a negedge and return at the following negedge.
  task automatic bus_write(input logic [15:0] data);
    cs = 1'b1; wr = 1'b1; addr = 4'h0; d_in = data;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] exp);
    rd_q.push_back(exp);
    cs = 1'b1; rd = 1'b1; addr = 4'h2;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; addr = 4'h0;
  endtask

  task automatic expect_pins(input int n, input logic en, input logic rst, input string name);
    for (int i = 0; i < n; i++) begin
      chk(name, {30'h0, mod_en, mod_rst}, {30'h0, en, rst});
      @(negedge clk);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    tests++;
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    chk("rst_pins", {30'h0, mod_en, mod_rst}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_dout", {16'h0, d_out}, 32'h0);
    bus_read(16'h0000);

    // Normal boot, response 5 cycles into WAIT_RSP
    bus_write(16'h0001);
    expect_pins(4, 1'b1, 1'b0, "t2_reset");
    expect_pins(8, 1'b1, 1'b1, "t2_boot");
    expect_pins(4, 1'b1, 1'b1, "t2_wait");
    done_q.push_back(2'b11);
    rx_activity = 1'b1;
    @(negedge clk);
    rx_activity = 1'b0;
    chk("t2_ready_pins", {30'h0, mod_en, mod_rst}, 32'h3);
    bus_read(16'h0082);

    // Restart from READY, rx only during BOOT, two timeouts then FAIL
    bus_write(16'h0001);
    expect_pins(4, 1'b1, 1'b0, "t3_reset1");
    for (int i = 0; i < 8; i++) begin
      chk("t3_boot1", {30'h0, mod_en, mod_rst}, 32'h3);
      rx_activity = (i == 2) || (i == 5);
      @(negedge clk);
    end
    rx_activity = 1'b0;
    expect_pins(16, 1'b1, 1'b1, "t3_wait1");
    expect_pins(4, 1'b1, 1'b0, "t3_reset2");
    expect_pins(8, 1'b1, 1'b1, "t3_boot2");
    bus_read(16'h0069);
    expect_pins(14, 1'b1, 1'b1, "t3_wait2");
    done_q.push_back(2'b00);
    expect_pins(1, 1'b1, 1'b1, "t3_wait2_last");
    chk("t3_fail_pins", {30'h0, mod_en, mod_rst}, 32'h0);
    bus_read(16'h00B4);

    // Start+abort during BOOT: IDLE next cycle, no done
    bus_write(16'h0001);
    expect_pins(4, 1'b1, 1'b0, "t4_reset");
    expect_pins(3, 1'b1, 1'b1, "t4_boot");
    bus_write(16'h0003);
    chk("t4_abort_pins", {30'h0, mod_en, mod_rst}, 32'h0);
    bus_read(16'h0000);
    expect_pins(4, 1'b0, 1'b0, "t4_idle");

    // Async reset during WAIT_RSP, then a clean restart
    bus_write(16'h0001);
    expect_pins(4, 1'b1, 1'b0, "t5_reset");
    expect_pins(8, 1'b1, 1'b1, "t5_boot");
    bus_read(16'h0061);
    repeat (2) @(negedge clk);
    #2 sys_rst = 1'b0;
    #1;
    chk("t5_async_pins", {30'h0, mod_en, mod_rst}, 32'h0);
    chk("t5_async_done", {31'h0, done}, 32'h0);
    chk("t5_async_dout", {16'h0, d_out}, 32'h0);
    repeat (2) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    chk("t5_idle_pins", {30'h0, mod_en, mod_rst}, 32'h0);
    bus_write(16'h0001);
    expect_pins(4, 1'b1, 1'b0, "t5_reset_again");
    expect_pins(2, 1'b1, 1'b1, "t5_boot_again");
    bus_read(16'h0041);
    repeat (3) @(negedge clk);

    chk("sb_rd_empty", rd_q.size(), 32'd0);
    chk("sb_done_empty", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
